// File: rtl/buffer_load_arbiter_pkg.sv
// Shared types for buffer_load_arbiter: the EMPTY/FULL state, default sizes and
// the wrap-around index helper used by the round-robin search.
package buffer_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    // Index reached by stepping 'offset' places up from 'base' in a ring of n.
    function automatic int wrap_idx(int base, int offset, int n);
        int s;
        s = base + offset;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/buffer_load_arbiter_if.sv
// Requester-side and consumer-side signals of buffer_load_arbiter.
// The producer side is acknowledged by gnt only; the consumer side is valid/ready.
interface buffer_load_arbiter_if
    import buffer_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // q transfers on a cycle where q_valid and q_ready are both 1; q_valid never
    // depends on q_ready, and the word is held unchanged while q_ready is 0.
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     flush;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;
    logic                     q_ready;
    logic [SRC_W-1:0]         q_src;
    logic                     timeout;
    state_t                   dbg_state;

    modport master (
        output req, data, flush, q_ready,
        input  gnt, q, q_valid, q_src, timeout, dbg_state
    );

    modport slave (
        input  req, data, flush, q_ready,
        output gnt, q, q_valid, q_src, timeout, dbg_state
    );

endinterface

// File: rtl/buffer_load_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or above the pointer, wrapping to 0.
// The index is always reported; the one-hot grant only when enabled.
module rr_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [SRC_W-1:0]   o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req[wrap_idx(int'(i_ptr), k, NUM_REQ)]) begin
                w_found = 1'b1;
                o_idx   = SRC_W'(wrap_idx(int'(i_ptr), k, NUM_REQ));
                o_gnt[wrap_idx(int'(i_ptr), k, NUM_REQ)] = i_en;
            end
        end
    end

endmodule

// File: rtl/buffer_load_arbiter.sv
// One shared buffer register loaded by round-robin among NUM_REQ requesters.
// Optional hold timeout compiled in with `define BUF_HOLD_TIMEOUT_EN.
module buffer_load_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    buffer_load_arbiter_if.slave  bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_q;
    logic [SRC_W-1:0]   r_src;
    logic [SRC_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic [SRC_W-1:0]   w_idx;
    logic               w_load_ok;
    logic               w_arb_en;
    logic               w_grant;
    logic               w_expire;
    logic               r_timeout;

    // A load slot exists when empty or when the held word leaves this cycle.
    assign w_load_ok = (r_state == EMPTY) || bus.q_ready;
    assign w_arb_en  = reset_n && w_load_ok && !bus.flush;
    assign w_grant   = |w_gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

`ifdef BUF_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold;

    assign w_hold   = (r_state == FULL) && !bus.q_ready && !bus.flush;
    assign w_expire = w_hold && (r_hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout  <= w_expire;
            r_hold_cnt <= (w_hold && !w_expire) ? r_hold_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_expire  = 1'b0;
    assign r_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = EMPTY;
        end else if (w_grant) begin
            w_next_state = FULL;
        end else if ((r_state == FULL) && bus.q_ready) begin
            w_next_state = EMPTY;
        end else if (w_expire) begin
            w_next_state = EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // q and q_src keep their last word after drain, flush or timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            r_src <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_q   <= bus.data[w_idx*WIDTH +: WIDTH];
            r_src <= w_idx;
            r_ptr <= (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.q         = r_q;
    assign bus.q_valid   = (r_state == FULL);
    assign bus.q_src     = r_src;
    assign bus.timeout   = r_timeout;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_buffer_load_arbiter.sv
// Self-checking bench for buffer_load_arbiter against a behavioural model of the
// shared buffer (held word, source, rotating priority, optional hold limit).
`timescale 1ns/1ps
module tb_buffer_load_arbiter;
    import buffer_arb_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]   req_v   = '0;
    logic [N*W-1:0] data_v  = '0;
    logic           flush_v = 1'b0;
    logic           ready_v = 1'b0;

    buffer_load_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
    assign bus.req     = req_v;
    assign bus.data    = data_v;
    assign bus.flush   = flush_v;
    assign bus.q_ready = ready_v;

    buffer_load_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic         exp_valid;
    logic [W-1:0] exp_q;
    logic [1:0]   exp_src;
    int           exp_ptr;
    int           exp_hold;
    logic         exp_timeout;
    logic [N-1:0] last_gnt;

    function automatic logic [N-1:0] exp_gnt_f();
        logic [N-1:0] g;
        g = '0;
        if (reset_n && (!exp_valid || ready_v) && !flush_v) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_v[(exp_ptr + k) % N]) begin
                    g = '0;
                    g[(exp_ptr + k) % N] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    task automatic reset_model();
        exp_valid   = 1'b0;
        exp_q       = '0;
        exp_src     = '0;
        exp_ptr     = 0;
        exp_hold    = 0;
        exp_timeout = 1'b0;
    endtask

    // Advance one clock and the model with it; returns at the following negedge.
    task automatic tick();
        logic [N-1:0] g;
        g = exp_gnt_f();
        last_gnt = g;
        @(posedge clock);
        exp_timeout = 1'b0;
        if (flush_v) begin
            exp_valid = 1'b0;
            exp_hold  = 0;
        end else if (g != '0) begin
            for (int j = 0; j < N; j++) begin
                if (g[j]) begin
                    exp_q   = data_v[j*W +: W];
                    exp_src = 2'(j);
                    exp_ptr = (j + 1) % N;
                end
            end
            exp_valid = 1'b1;
            exp_hold  = 0;
        end else if (exp_valid && !ready_v) begin
`ifdef BUF_HOLD_TIMEOUT_EN
            exp_hold++;
            if (exp_hold == TO) begin
                exp_valid   = 1'b0;
                exp_timeout = 1'b1;
                exp_hold    = 0;
            end
`endif
        end else begin
            exp_valid = 1'b0;
            exp_hold  = 0;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_model();
        reset_n = 1'b0;
        req_v   = 4'b1111;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", bus.q); end
        n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.q_valid); end
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        n_checks++; if (bus.q_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus.q_src); end
        reset_n = 1'b1;
        ready_v = 1'b0;
        req_v   = 4'b0100;
        data_v  = 16'h0D00;
        #1;
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL first_gnt: got %b want 0100", bus.gnt); end
        tick();
        req_v = 4'b0000;
        n_checks++; if (bus.q !== 4'hD || bus.q_valid !== 1'b1 || bus.q_src !== 2'd2) begin
            n_fail++; $display("FAIL first_load: got q=%h v=%b src=%0d want q=d v=1 src=2", bus.q, bus.q_valid, bus.q_src);
        end
    endtask

    task automatic test_backpressure();
        req_v  = 4'b0001;
        data_v = 16'h0009;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL bp_gnt: cycle %0d got %b want 0000", c, bus.gnt); end
            tick();
            n_checks++; if (bus.q !== 4'hD || bus.q_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got q=%h v=%b want q=d v=1", c, bus.q, bus.q_valid);
            end
        end
        ready_v = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL bp_release_gnt: got %b want 0001", bus.gnt); end
        tick();
        req_v   = 4'b0000;
        ready_v = 1'b0;
        n_checks++; if (bus.q !== 4'h9 || bus.q_src !== 2'd0 || bus.q_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_reload: got q=%h src=%0d v=%b want q=9 src=0 v=1", bus.q, bus.q_src, bus.q_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // asynchronous reset while a word is held
        #2 reset_n = 1'b0;
        reset_model();
        #1;
        n_checks++; if (bus.q_valid !== 1'b0 || bus.q !== 4'h0) begin
            n_fail++; $display("FAIL midhold_reset: got q=%h v=%b want q=0 v=0", bus.q, bus.q_valid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        data_v  = 16'hA5C3;
        req_v   = 4'b1111;
        ready_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (bus.gnt !== seq[k]) begin n_fail++; $display("FAIL rr_gnt: step %0d got %b want %b", k, bus.gnt, seq[k]); end
            tick();
            n_checks++; if (bus.q_valid !== 1'b1 || bus.q !== exp_q || bus.q_src !== 2'(k % N)) begin
                n_fail++; $display("FAIL rr_load: step %0d got q=%h v=%b src=%0d want q=%h v=1 src=%0d", k, bus.q, bus.q_valid, bus.q_src, exp_q, k % N);
            end
        end
    endtask

    task automatic test_drain();
        req_v   = 4'b0000;
        ready_v = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL drain_gnt: got %b want 0000", bus.gnt); end
        tick();
        n_checks++; if (bus.q_valid !== 1'b0 || bus.q !== 4'h3 || bus.q_src !== 2'd0) begin
            n_fail++; $display("FAIL drain: got q=%h v=%b src=%0d want q=3 v=0 src=0", bus.q, bus.q_valid, bus.q_src);
        end
    endtask

    task automatic test_flush();
        req_v = 4'b0100;
        tick();
        flush_v = 1'b1;
        req_v   = 4'b0010;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL flush_gnt: got %b want 0000", bus.gnt); end
        tick();
        n_checks++; if (bus.q_valid !== 1'b0 || bus.q !== 4'h5) begin
            n_fail++; $display("FAIL flush_clear: got q=%h v=%b want q=5 v=0", bus.q, bus.q_valid);
        end
        flush_v = 1'b0;
        req_v   = 4'b1111;
        #1;
        // last winner was requester 2, so requester 3 is next in line
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL flush_ptr: got %b want 1000", bus.gnt); end
        tick();
        req_v = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        int want_pulses;
        pulses  = 0;
        ready_v = 1'b0;
        req_v   = 4'b0010;
        tick();
        req_v = 4'b0000;
`ifdef BUF_HOLD_TIMEOUT_EN
        want_pulses = 1;
`else
        want_pulses = 0;
`endif
        for (int c = 0; c < TO + 4; c++) begin
            tick();
            if (bus.timeout === 1'b1) pulses++;
            n_checks++; if (bus.q_valid !== exp_valid || bus.timeout !== exp_timeout) begin
                n_fail++; $display("FAIL hold_limit: cycle %0d got v=%b to=%b want v=%b to=%b", c, bus.q_valid, bus.timeout, exp_valid, exp_timeout);
            end
        end
        n_checks++; if (pulses != want_pulses) begin n_fail++; $display("FAIL timeout_pulses: got %0d want %0d", pulses, want_pulses); end
        ready_v = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i] && $urandom_range(1, 0) == 0) req_v[i] = 1'b0;
                if (!req_v[i] && $urandom_range(2, 0) == 0) begin
                    req_v[i] = 1'b1;
                    data_v[i*W +: W] = W'($urandom);
                end
            end
            ready_v = ($urandom_range(3, 0) != 0);
            flush_v = ($urandom_range(15, 0) == 0);
            #1;
            g = exp_gnt_f();
            n_checks++; if (bus.gnt !== g) begin n_fail++; $display("FAIL rand_gnt: cycle %0d got %b want %b", c, bus.gnt, g); end
            tick();
            n_checks++; if (bus.q_valid !== exp_valid || bus.q !== exp_q || bus.q_src !== exp_src
                            || bus.timeout !== exp_timeout || bus.dbg_state !== (exp_valid ? FULL : EMPTY)) begin
                n_fail++; $display("FAIL rand_out: cycle %0d got q=%h v=%b src=%0d to=%b want q=%h v=%b src=%0d to=%b",
                                   c, bus.q, bus.q_valid, bus.q_src, bus.timeout, exp_q, exp_valid, exp_src, exp_timeout);
            end
        end
        flush_v = 1'b0;
    endtask

    initial begin
        last_gnt = '0;
        test_reset();
        test_backpressure();
        test_round_robin();
        test_drain();
        test_flush();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_load_arbiter.md
Name: buffer_load_arbiter

Overview:
- Shares one WIDTH-bit buffer register among NUM_REQ requesters.
- Round-robin arbitration; the granted word loads into the buffer, which then holds it until the consumer accepts it.
- Sits between several producer blocks and the single buffer-register stage that feeds downstream logic.
- Output is a valid/ready handshake that reports which source produced the held word.

Parameters:
- WIDTH, 4, data width of the buffer register.
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, $clog2(NUM_REQ), width of the source-ID field.
- TIMEOUT_CYCLES, 16, hold limit in cycles; used only when the optional feature is compiled in.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester load request, level.
- data  input  NUM_REQ*WIDTH  flattened words; requester i occupies [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot grant, combinational, valid in the cycle the word is captured.
- flush  input  1  synchronous clear of the held word.
- q  output  WIDTH  buffer register contents.
- q_valid  output  1  buffer holds an unconsumed word.
- q_ready  input  1  consumer accepts q in this cycle when q_valid=1.
- q_src  output  SRC_W  index of the requester whose word is in q.
- timeout  output  1  one-cycle pulse when a held word is dropped (optional feature).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - q=0, q_valid=0, q_src=0, timeout=0.
  - rr pointer=0; state=EMPTY.
  - gnt=0 while reset_n is low.
- States: EMPTY (q_valid=0) and FULL (q_valid=1). state and q_valid are the same bit.
- Load slot: load_ok = (state==EMPTY) | (state==FULL & q_ready).
- gnt:
  - Asserted only when load_ok & |req & ~flush.
  - Winner is the first requester with req=1, searching from the rr pointer upward with wrap at NUM_REQ-1 -> 0.
  - gnt is zero at all other times.
- On an edge with a grant:
  - q <= winner's word; q_src <= winner; state <= FULL.
  - rr pointer <= (winner+1) mod NUM_REQ.
- Load latency: a word granted in cycle N is visible on q with q_valid=1 in cycle N+1.
- Throughput: accept and reload in the same cycle (FULL & q_ready & req) keeps q_valid=1 and replaces q. Sustained rate is one word per cycle.
- FULL & q_ready & no req: state <= EMPTY. q and q_src keep their last values.
- FULL & ~q_ready: q, q_src and q_valid are held. req is ignored and gnt=0.
- flush=1 (highest priority): state <= EMPTY, gnt=0, rr pointer unchanged, q retains its value. flush in EMPTY has no effect.
- A requester must hold req and data stable until it sees gnt; gnt is its only acknowledge.
- A single requester asserting req continuously is granted on every load slot; fairness only applies under contention.
- reset_n asserted mid-hold discards the held word immediately.

Optional Feature:
- Macro: BUF_HOLD_TIMEOUT_EN.
- Compiled in:
  - A hold counter counts consecutive FULL & ~q_ready cycles.
  - When the count reaches TIMEOUT_CYCLES: state <= EMPTY and timeout pulses for one cycle.
  - The counter clears on any accept, load, flush or reset.
- Compiled out: no counter is built, timeout is tied to 0, and a word is held indefinitely.

Decomposition:
- Package buffer_arb_pkg: the state enum (EMPTY, FULL) and localparam defaults for WIDTH and NUM_REQ.
- Sub-module rr_arbiter (NUM_REQ): takes req, pointer and enable; returns a one-hot gnt and the binary winner index.
- The top level holds the buffer register, state bit, rr pointer update and optional timeout counter.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 -> q=0, q_valid=0, gnt=0, q_src=0. Release reset, q_ready=0, req=4'b0100 with data[2]=4'b1101 -> gnt=4'b0100 in the first cycle; next cycle q=1101, q_valid=1, q_src=2.
- Backpressure: with FULL, q_ready=0 for 5 cycles and req=4'b0001 -> gnt=0 throughout and q stays 1101. Then q_ready=1 -> gnt=0001 that cycle; next cycle q=data[0]=1001, q_src=0.
- Round-robin: req=4'b1111 with q_ready=1 permanently, pointer starting at 0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with q_valid=1 continuously.
- Drain: q_ready=1 and req=0 while FULL -> q_valid=0 next cycle and q unchanged.
- flush: flush=1 coincident with q_ready=1 and req=0010 -> gnt=0 and q_valid=0 next cycle; the rr pointer is unchanged, verified by the next grant order.
- Timeout (BUF_HOLD_TIMEOUT_EN, TIMEOUT_CYCLES=16): FULL with q_ready=0 for 16 cycles -> timeout=1 for exactly one cycle, then q_valid=0. Without the macro -> q_valid remains 1 and timeout=0.
